cmd_serializer: RTL

Upstream command source for the single-bit control core. It accepts parallel command words over a valid/ready handshake and buffers them in a small FIFO. It shifts each word out LSB-first, one bit per clock, on the serial `cmd` line that the core's `cmd` input consumes. When no word is pending it drives a fixed idle level so the core's feedback flop holds state.

---
 rtl/cmd_serializer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cmd_serializer.sv
// Parallel-to-serial command source: a small FIFO feeds a shifter that sends each word LSB-first on cmd.
// When nothing is being shifted, cmd sits at IDLE_LEVEL so the downstream feedback flop holds its state.
//   state   | meaning
//   S_IDLE  | no word in the shifter, cmd = IDLE_LEVEL
//   S_SHIFT | shifter active, cmd carries data bit bit_cnt
module cmd_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   DEPTH      = 4,
    parameter int   CNT_W      = 16,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         cmd,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [CNT_W-1:0]             words_sent
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(WIDTH);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] head;

    logic [0:0]       state;
    logic [WIDTH-2:0] shreg;
    logic [BW-1:0]    bit_cnt;

    logic push;
    logic pop;
    logic fifo_nonempty;
    logic last_bit;

    assign head = mem[rd_ptr];
    assign busy = (state == S_SHIFT);

    // in_ready deliberately ignores a same-edge pop so a full FIFO always back-pressures.
    always_comb begin
        fifo_nonempty = (fifo_count != '0);
        last_bit      = (state == S_SHIFT) && (bit_cnt == LAST_BIT);
        in_ready      = (fifo_count < FULL_CNT) && !abort && rst;
        push          = in_valid && in_ready;
        pop           = !abort && fifo_nonempty && ((state == S_IDLE) || last_bit);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // shreg holds the bits not yet on cmd; bit 0 of a popped word goes straight to cmd.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cmd        <= IDLE_LEVEL;
            shreg      <= '0;
            bit_cnt    <= '0;
            words_sent <= '0;
        end else if (abort) begin
            state   <= S_IDLE;
            cmd     <= IDLE_LEVEL;
            bit_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg   <= head[WIDTH-1:1];
                        cmd     <= head[0];
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                    end else begin
                        cmd <= IDLE_LEVEL;
                    end
                end
                S_SHIFT: begin
                    if (!last_bit) begin
                        bit_cnt <= bit_cnt + BW'(1);
                        cmd     <= shreg[0];
                        shreg   <= shreg >> 1;
                    end else begin
                        words_sent <= words_sent + CNT_W'(1);
                        if (pop) begin
                            shreg   <= head[WIDTH-1:1];
                            cmd     <= head[0];
                            bit_cnt <= '0;
                        end else begin
                            cmd     <= IDLE_LEVEL;
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cmd   <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule
